// File: rtl/clint_mh.sv
// clint_mh -- multi-hart core-local interruptor.
//
// Holds one MSIP bit and one 64-bit MTIMECMP per hart, plus a single shared
// 64-bit MTIME that advances once every TIMER_DIV core clocks unless the
// debug freeze input is high. Registers are reachable over a simple
// byte/half/word peripheral bus with registered (1-cycle) read data.
//
// Ports:
//   clk, rst_n                   clock and asynchronous active-low reset
//   bus_clint_read_addr/size     read byte address and access size
//   bus_clint_write_addr/size    write byte address and access size
//   bus_clint_data               right-aligned write data
//   bus_clint_rd / bus_clint_wr  read / write strobes
//   mtime_freeze                 holds MTIME and the prescaler while high
//   clint_bus_data               registered read data
//   all_intif_int_software_req   per-hart MSIP bit
//   all_intif_int_timer_req      per-hart (MTIME >= MTIMECMP) request
//
// Address map: MSIP[h] @ 0x0000+4h, MTIMECMP[h] @ 0x4000+8h (lo) / +4 (hi),
// MTIME @ 0xbff8 (lo) / 0xbffc (hi). Size codes: 00 byte, 01 half, 10 word.

module clint_mh #(
    parameter int HART_NUM       = 1,
    parameter int TIMER_DIV      = 1,
    parameter int DIV_WIDTH      = 16,
    parameter int ADDR_WIDTH     = 16,
    parameter int SIZE_WIDTH     = 2,
    parameter int REG_DATA_WIDTH = 32,
    parameter int BUS_DATA_WIDTH = 32
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [ADDR_WIDTH-1:0]     bus_clint_read_addr,
    input  logic [ADDR_WIDTH-1:0]     bus_clint_write_addr,
    input  logic [SIZE_WIDTH-1:0]     bus_clint_read_size,
    input  logic [SIZE_WIDTH-1:0]     bus_clint_write_size,
    input  logic [REG_DATA_WIDTH-1:0] bus_clint_data,
    input  logic                      bus_clint_rd,
    input  logic                      bus_clint_wr,
    input  logic                      mtime_freeze,
    output logic [BUS_DATA_WIDTH-1:0] clint_bus_data,
    output logic [HART_NUM-1:0]       all_intif_int_software_req,
    output logic [HART_NUM-1:0]       all_intif_int_timer_req
);

    localparam logic [1:0] KIND_NONE = 2'd0;
    localparam logic [1:0] KIND_MSIP = 2'd1;
    localparam logic [1:0] KIND_CMP  = 2'd2;
    localparam logic [1:0] KIND_TIME = 2'd3;

    typedef struct packed {
        logic       ok;
        logic [1:0] kind;
        logic [3:0] hart;
        logic       hi;
    } dec_t;

    // Decodes one access. Anything misaligned, of reserved size, unmapped or
    // aimed at a non-existent hart comes back with ok=0 and kind=NONE, so
    // writes are dropped and reads return zero without further checks.
    function automatic dec_t decode(input logic [ADDR_WIDTH-1:0] addr,
                                    input logic [1:0] size);
        logic [31:0] a;
        logic        aligned;
        dec_t        d;
        a = 32'(addr);
        d = '0;
        case (size)
            2'd0:    aligned = 1'b1;
            2'd1:    aligned = ~a[0];
            2'd2:    aligned = (a[1:0] == 2'd0);
            default: aligned = 1'b0;
        endcase
        if (a < 32'h4000) begin
            if (a[13:2] < 12'(HART_NUM)) d.kind = KIND_MSIP;
        end else if (a < 32'h4000 + 32'(8 * HART_NUM)) begin
            d.kind = KIND_CMP;
        end else if (a >= 32'hbff8 && a <= 32'hbfff) begin
            d.kind = KIND_TIME;
        end
        d.hart = (d.kind == KIND_MSIP) ? a[5:2] : a[6:3];
        d.hi   = a[2];
        d.ok   = aligned && (d.kind != KIND_NONE);
        if (!d.ok) d.kind = KIND_NONE;
        return d;
    endfunction

    logic [HART_NUM-1:0]  msip;
    logic [63:0]          mtimecmp [HART_NUM];
    logic [63:0]          mtime;
    logic [DIV_WIDTH-1:0] div_cnt;
    logic                 tick;

    dec_t        rdec;
    dec_t        wdec;
    logic [31:0] rword;
    logic [31:0] rshift;
    logic [31:0] rdata;
    logic [31:0] wmask;
    logic [31:0] wlane;
    logic        wen;

    assign tick = ~mtime_freeze && (div_cnt == DIV_WIDTH'(TIMER_DIV - 1));
    assign all_intif_int_software_req = msip;

    // Read path: pick the addressed 32-bit word, then right-align the
    // requested lane and mask it to the access size.
    always_comb begin
        rdec  = decode(bus_clint_read_addr, bus_clint_read_size[1:0]);
        rword = '0;
        case (rdec.kind)
            KIND_MSIP: begin
                for (int h = 0; h < HART_NUM; h++)
                    if (rdec.hart == 4'(h)) rword = {31'b0, msip[h]};
            end
            KIND_CMP: begin
                for (int h = 0; h < HART_NUM; h++)
                    if (rdec.hart == 4'(h))
                        rword = rdec.hi ? mtimecmp[h][63:32] : mtimecmp[h][31:0];
            end
            KIND_TIME: rword = rdec.hi ? mtime[63:32] : mtime[31:0];
            default:   rword = '0;
        endcase
        rshift = rword >> {bus_clint_read_addr[1:0], 3'b000};
        case (bus_clint_read_size[1:0])
            2'd0:    rdata = {24'b0, rshift[7:0]};
            2'd1:    rdata = {16'b0, rshift[15:0]};
            default: rdata = rshift;
        endcase
        if (!rdec.ok) rdata = '0;
    end

    // Write path: build a bit mask of the selected bytes and shift the
    // right-aligned data into the matching lanes.
    always_comb begin
        wdec  = decode(bus_clint_write_addr, bus_clint_write_size[1:0]);
        wen   = bus_clint_wr && wdec.ok;
        wmask = '0;
        case (bus_clint_write_size[1:0])
            2'd0:    wmask = 32'h0000_00ff << {bus_clint_write_addr[1:0], 3'b000};
            2'd1:    wmask = 32'h0000_ffff << {bus_clint_write_addr[1:0], 3'b000};
            default: wmask = 32'hffff_ffff;
        endcase
        wlane = bus_clint_data[31:0] << {bus_clint_write_addr[1:0], 3'b000};
    end

    // Prescaler: free-running modulo-TIMER_DIV counter that simply stops
    // while frozen, so MTIME resumes mid-period after a debug halt.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)            div_cnt <= '0;
        else if (tick)         div_cnt <= '0;
        else if (!mtime_freeze) div_cnt <= div_cnt + 1'b1;
    end

    // MTIME: a bus write to either half takes priority over the tick, and
    // the untouched half is held as-is (no carry from the dropped increment).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mtime <= '0;
        end else if (wen && wdec.kind == KIND_TIME) begin
            if (wdec.hi) mtime[63:32] <= (mtime[63:32] & ~wmask) | (wlane & wmask);
            else         mtime[31:0]  <= (mtime[31:0]  & ~wmask) | (wlane & wmask);
        end else if (tick) begin
            mtime <= mtime + 64'd1;
        end
    end

    // Per-hart MSIP and MTIMECMP registers. MSIP only keeps bit 0, so only a
    // write covering byte 0 can change it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            msip <= '0;
            for (int h = 0; h < HART_NUM; h++) mtimecmp[h] <= '1;
        end else if (wen) begin
            for (int h = 0; h < HART_NUM; h++) begin
                if (wdec.hart == 4'(h)) begin
                    if (wdec.kind == KIND_MSIP && wmask[0])
                        msip[h] <= wlane[0];
                    if (wdec.kind == KIND_CMP) begin
                        if (wdec.hi)
                            mtimecmp[h][63:32] <= (mtimecmp[h][63:32] & ~wmask) | (wlane & wmask);
                        else
                            mtimecmp[h][31:0]  <= (mtimecmp[h][31:0]  & ~wmask) | (wlane & wmask);
                    end
                end
            end
        end
    end

    // Timer requests are a registered level compare on pre-edge values;
    // they follow the condition both ways with one cycle of delay.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            all_intif_int_timer_req <= '0;
        end else begin
            for (int h = 0; h < HART_NUM; h++)
                all_intif_int_timer_req[h] <= (mtime >= mtimecmp[h]);
        end
    end

    // Registered read data; holds its last value when no read is strobed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)            clint_bus_data <= '0;
        else if (bus_clint_rd) clint_bus_data <= BUS_DATA_WIDTH'(rdata);
    end

endmodule
